// File: rtl/inst_cache_pkg.sv
// Shared types and constants for the instruction cache: bus FSM states, TileLink
// opcode, default geometry and the halfword select helper.
package inst_cache_pkg;

  localparam int DEF_SETS       = 64;
  localparam int DEF_LINE_BYTES = 32;
  localparam int DEF_ADDR_W     = 64;

  localparam int OFF_W = $clog2(DEF_LINE_BYTES);
  localparam int IDX_W = $clog2(DEF_SETS);
  localparam int TAG_W = DEF_ADDR_W - OFF_W - IDX_W;

  localparam logic [2:0]  TL_GET = 3'd4;
  localparam logic [31:0] BUBBLE = 32'h0000_0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [15:0] pick_half(input logic [63:0] word, input logic [1:0] sel);
    case (sel)
      2'd0:    return word[15:0];
      2'd1:    return word[31:16];
      2'd2:    return word[47:32];
      default: return word[63:48];
    endcase
  endfunction

endpackage

// File: rtl/inst_cache_refill.sv
// Line refill engine: one TileLink-UL Get per missing line, then LINE_BYTES/8 data
// beats streamed out as write strobes for the top-level arrays.
module inst_cache_refill
  import inst_cache_pkg::*;
#(
  parameter  int LINE_BYTES = DEF_LINE_BYTES,
  parameter  int ADDR_W     = DEF_ADDR_W,
  localparam int OFF_BITS   = $clog2(LINE_BYTES),
  localparam int LINE_W     = ADDR_W - OFF_BITS,
  localparam int BEATS      = LINE_BYTES / 8,
  localparam int BEAT_BITS  = $clog2(BEATS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss,
  input  logic [LINE_W-1:0]    miss_line,
  output logic                 request,
  output logic                 a_valid,
  input  logic                 a_ready,
  output logic [2:0]           a_opcode,
  output logic [3:0]           a_size,
  output logic [ADDR_W-1:0]    a_address,
  input  logic                 d_valid,
  output logic                 d_ready,
  output logic                 wr_en,
  output logic [BEAT_BITS-1:0] wr_beat,
  output logic [LINE_W-1:0]    wr_line,
  output logic                 fill_done
);

  state_t               state_r;
  logic [LINE_W-1:0]    line_r;
  logic [BEAT_BITS-1:0] beat_cnt_r;
  logic                 request_r;
  logic                 a_valid_r;
  logic                 d_ready_r;
  logic                 accept_s;
  logic                 last_beat_s;

  assign accept_s    = d_ready_r & d_valid;
  assign last_beat_s = (beat_cnt_r == BEAT_BITS'(BEATS - 1));

  // Bus FSM; request spans from leaving IDLE until the last beat is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      line_r     <= '0;
      beat_cnt_r <= '0;
      request_r  <= 1'b0;
      a_valid_r  <= 1'b0;
      d_ready_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (miss) begin
            line_r    <= miss_line;
            request_r <= 1'b1;
            a_valid_r <= 1'b1;
            state_r   <= REQ;
          end
        end
        REQ: begin
          if (a_ready) begin
            a_valid_r  <= 1'b0;
            d_ready_r  <= 1'b1;
            beat_cnt_r <= '0;
            state_r    <= RESP;
          end
        end
        RESP: begin
          if (accept_s) begin
            if (last_beat_s) begin
              beat_cnt_r <= '0;
              d_ready_r  <= 1'b0;
              request_r  <= 1'b0;
              state_r    <= IDLE;
            end else begin
              beat_cnt_r <= beat_cnt_r + BEAT_BITS'(1);
            end
          end
        end
        default: begin
          beat_cnt_r <= '0;
          request_r  <= 1'b0;
          a_valid_r  <= 1'b0;
          d_ready_r  <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign request   = request_r;
  assign a_valid   = a_valid_r;
  assign d_ready   = d_ready_r;
  assign a_opcode  = TL_GET;
  assign a_size    = 4'(OFF_BITS);
  assign a_address = {line_r, {OFF_BITS{1'b0}}};
  assign wr_en     = accept_s;
  assign wr_beat   = beat_cnt_r;
  assign wr_line   = line_r;
  assign fill_done = accept_s & last_beat_s;

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with combinational lookup and TileLink-UL
// line refill. Optional INST_CACHE_FLUSH_EN adds a flush input that drops every line.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int SETS       = DEF_SETS,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef INST_CACHE_FLUSH_EN
  input  logic              flush,
`endif
  input  logic [ADDR_W-1:0] pc,
  output logic              inst_valid,
  output logic              inst_compressed,
  output logic [31:0]       inst,
  output logic              request,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [2:0]        a_opcode,
  output logic [3:0]        a_size,
  output logic [ADDR_W-1:0] a_address,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [63:0]       d_data
);

  localparam int OFF_BITS  = $clog2(LINE_BYTES);
  localparam int IDX_BITS  = $clog2(SETS);
  localparam int TAG_BITS  = ADDR_W - OFF_BITS - IDX_BITS;
  localparam int LINE_W    = ADDR_W - OFF_BITS;
  localparam int BEATS     = LINE_BYTES / 8;
  localparam int BEAT_BITS = $clog2(BEATS);
  localparam int HOFF_BITS = OFF_BITS - 1;
  localparam int HADDR_W   = ADDR_W - 1;

  logic [63:0]         data_r [SETS][BEATS];
  logic [TAG_BITS-1:0] tag_r  [SETS];
  logic [SETS-1:0]     valid_r;
  logic                poison_r;

  logic                 flush_s;
  logic                 unused_pc_lsb_s;
  logic [HADDR_W-1:0]   hpc0_s;
  logic [HADDR_W-1:0]   hpc1_s;
  logic [IDX_BITS-1:0]  idx0_s;
  logic [IDX_BITS-1:0]  idx1_s;
  logic [TAG_BITS-1:0]  tag0_s;
  logic [TAG_BITS-1:0]  tag1_s;
  logic [LINE_W-1:0]    line0_s;
  logic [LINE_W-1:0]    line1_s;
  logic                 hit0_s;
  logic                 hit1_s;
  logic [15:0]          h0_s;
  logic [15:0]          h1_s;
  logic                 comp_s;
  logic                 miss_s;
  logic [LINE_W-1:0]    miss_line_s;
  logic                 wr_en_s;
  logic [BEAT_BITS-1:0] wr_beat_s;
  logic [LINE_W-1:0]    wr_line_s;
  logic                 fill_done_s;
  logic [IDX_BITS-1:0]  wr_idx_s;
  logic [TAG_BITS-1:0]  wr_tag_s;

`ifdef INST_CACHE_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Work in halfword addresses; the second halfword may fall in the following line.
  assign unused_pc_lsb_s = pc[0];
  assign hpc0_s  = pc[ADDR_W-1:1];
  assign hpc1_s  = hpc0_s + HADDR_W'(1);
  assign idx0_s  = hpc0_s[HOFF_BITS +: IDX_BITS];
  assign idx1_s  = hpc1_s[HOFF_BITS +: IDX_BITS];
  assign tag0_s  = hpc0_s[HADDR_W-1 -: TAG_BITS];
  assign tag1_s  = hpc1_s[HADDR_W-1 -: TAG_BITS];
  assign line0_s = hpc0_s[HADDR_W-1:HOFF_BITS];
  assign line1_s = hpc1_s[HADDR_W-1:HOFF_BITS];

  assign hit0_s = valid_r[idx0_s] & (tag_r[idx0_s] == tag0_s);
  assign hit1_s = valid_r[idx1_s] & (tag_r[idx1_s] == tag1_s);
  assign h0_s   = pick_half(data_r[idx0_s][hpc0_s[HOFF_BITS-1:2]], hpc0_s[1:0]);
  assign h1_s   = pick_half(data_r[idx1_s][hpc1_s[HOFF_BITS-1:2]], hpc1_s[1:0]);
  assign comp_s = (h0_s[1:0] != 2'b11);

  // Instruction presentation; a bubble whenever any needed line is absent.
  always_comb begin
    inst_valid      = 1'b0;
    inst_compressed = 1'b0;
    inst            = BUBBLE;
    if (hit0_s && (comp_s || hit1_s) && !flush_s) begin
      inst_valid = 1'b1;
      if (comp_s) begin
        inst_compressed = 1'b1;
        inst            = {16'h0000, h0_s};
      end else begin
        inst_compressed = 1'b0;
        inst            = {h1_s, h0_s};
      end
    end else begin
      inst_valid      = 1'b0;
      inst_compressed = 1'b0;
      inst            = BUBBLE;
    end
  end

  // Miss selection; the line holding the first halfword is fetched first.
  always_comb begin
    miss_s      = 1'b0;
    miss_line_s = line0_s;
    if (!hit0_s) begin
      miss_s      = 1'b1;
      miss_line_s = line0_s;
    end else if (!comp_s && !hit1_s) begin
      miss_s      = 1'b1;
      miss_line_s = line1_s;
    end else begin
      miss_s      = 1'b0;
      miss_line_s = line0_s;
    end
  end

  inst_cache_refill #(
    .LINE_BYTES (LINE_BYTES),
    .ADDR_W     (ADDR_W)
  ) u_refill (
    .clk       (clk),
    .rst       (rst_n),
    .miss      (miss_s),
    .miss_line (miss_line_s),
    .request   (request),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_opcode  (a_opcode),
    .a_size    (a_size),
    .a_address (a_address),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .wr_en     (wr_en_s),
    .wr_beat   (wr_beat_s),
    .wr_line   (wr_line_s),
    .fill_done (fill_done_s)
  );

  assign wr_idx_s = wr_line_s[IDX_BITS-1:0];
  assign wr_tag_s = wr_line_s[LINE_W-1:IDX_BITS];

  // Data and tag storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      data_r[wr_idx_s][wr_beat_s] <= d_data;
    end
    if (fill_done_s) begin
      tag_r[wr_idx_s] <= wr_tag_s;
    end
  end

  // Valid bits; a flush seen during a refill keeps that line from becoming valid.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      valid_r  <= '0;
      poison_r <= 1'b0;
    end else begin
      if (fill_done_s) begin
        poison_r <= 1'b0;
      end else if (flush_s && request) begin
        poison_r <= 1'b1;
      end
      if (flush_s) begin
        valid_r <= '0;
      end else if (fill_done_s && !poison_r) begin
        valid_r[wr_idx_s] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: a TileLink slave backed by a synthetic memory, an
// address-level cache model checked every cycle, plus hand-computed spot checks.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pc;
  logic        inst_valid;
  logic        inst_compressed;
  logic [31:0] inst;
  logic        request;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [3:0]  a_size;
  logic [63:0] a_address;
  logic        d_valid;
  logic        d_ready;
  logic [63:0] d_data;
`ifdef INST_CACHE_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  inst_cache dut (
    .clk             (clk),
    .rst_n           (rst_n),
`ifdef INST_CACHE_FLUSH_EN
    .flush           (flush),
`endif
    .pc              (pc),
    .inst_valid      (inst_valid),
    .inst_compressed (inst_compressed),
    .inst            (inst),
    .request         (request),
    .a_valid         (a_valid),
    .a_ready         (a_ready),
    .a_opcode        (a_opcode),
    .a_size          (a_size),
    .a_address       (a_address),
    .d_valid         (d_valid),
    .d_ready         (d_ready),
    .d_data          (d_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory: a few pinned halfwords, everything else a fixed address hash.
  function automatic logic [15:0] mem_half(input logic [63:0] a);
    case (a)
      64'h1000: return 16'h0197;
      64'h1002: return 16'h1122;
      64'h1004: return 16'h4501;
      64'h1008: return 16'h0013;
      64'h100A: return 16'h0000;
      64'h101E: return 16'h0513;
      64'h1020: return 16'h1234;
      64'h103E: return 16'h0793;
      default:  return a[16:1] ^ 16'hA5C3;
    endcase
  endfunction

  function automatic logic [63:0] beat_data(input logic [63:0] b);
    return {mem_half(b + 64'd6), mem_half(b + 64'd4), mem_half(b + 64'd2), mem_half(b)};
  endfunction

  // Cache model: which line addresses are resident, and the refill in progress.
  int          m_stage;
  int          m_beats;
  logic [63:0] m_line;
  bit          m_valid [64];
  logic [52:0] m_tag   [64];

  function automatic bit line_hit(input logic [63:0] a);
    return m_valid[a[10:5]] && (m_tag[a[10:5]] == a[63:11]);
  endfunction

  function automatic logic [63:0] line_of(input logic [63:0] a);
    return {a[63:5], 5'b00000};
  endfunction

  function automatic bit exp_miss();
    logic [63:0] a0;
    logic [15:0] h;
    a0 = {pc[63:1], 1'b0};
    h  = mem_half(a0);
    return !line_hit(a0) || ((h[1:0] == 2'b11) && !line_hit(a0 + 64'd2));
  endfunction

  function automatic logic [63:0] exp_miss_line();
    logic [63:0] a0;
    a0 = {pc[63:1], 1'b0};
    return line_hit(a0) ? line_of(a0 + 64'd2) : line_of(a0);
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      m_stage <= 0;
      m_beats <= 0;
      for (int i = 0; i < 64; i++) m_valid[i] <= 1'b0;
    end else begin
      case (m_stage)
        0: if (exp_miss()) begin
             m_stage <= 1;
             m_line  <= exp_miss_line();
           end
        1: if (a_valid && a_ready) begin
             m_stage <= 2;
             m_beats <= 0;
           end
        2: if (d_valid) begin
             if (m_beats == 3) begin
               m_valid[m_line[10:5]] <= 1'b1;
               m_tag[m_line[10:5]]   <= m_line[63:11];
               m_stage               <= 0;
             end else begin
               m_beats <= m_beats + 1;
             end
           end
        default: m_stage <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, sampled after inputs have settled.
  always begin
    logic [63:0] a0, a1;
    logic [15:0] h0;
    bit          comp, ev;
    logic [31:0] einst;
    @(negedge clk);
    #2;
    if (chk_en) begin
      a0    = {pc[63:1], 1'b0};
      a1    = a0 + 64'd2;
      h0    = mem_half(a0);
      comp  = (h0[1:0] != 2'b11);
      ev    = line_hit(a0) && (comp || line_hit(a1));
      einst = !ev ? 32'h0000_0001 : (comp ? {16'h0000, h0} : {mem_half(a1), h0});
      check("inst_valid", 64'(inst_valid), 64'(ev));
      check("inst", 64'(inst), 64'(einst));
      check("inst_compressed", 64'(inst_compressed), 64'(ev && comp));
      check("request", 64'(request), 64'(m_stage != 0));
      check("a_valid", 64'(a_valid), 64'(m_stage == 1));
      check("d_ready", 64'(d_ready), 64'(m_stage == 2));
      if (m_stage == 1) begin
        check("a_address", a_address, m_line);
        check("a_opcode", 64'(a_opcode), 64'd4);
        check("a_size", 64'(a_size), 64'd5);
      end
    end
  end

  // TileLink slave: one wait cycle before a_ready, then four beats with a gap after the second.
  initial begin
    logic [63:0] base;
    a_ready = 1'b0;
    d_valid = 1'b0;
    d_data  = 64'd0;
    forever begin
      @(negedge clk);
      if (a_valid === 1'b1) begin
        base = a_address;
        @(negedge clk);
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          d_valid = 1'b1;
          d_data  = beat_data(base + 64'(8 * k));
          @(negedge clk);
          if (k == 1) begin
            d_valid = 1'b0;
            d_data  = 64'd0;
            @(negedge clk);
          end
        end
        d_valid = 1'b0;
        d_data  = 64'd0;
      end
    end
  end

  task automatic wait_valid(input string name, input int limit);
    int n;
    n = 0;
    while (!inst_valid && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 64'(inst_valid), 64'd1);
  endtask

  initial begin
    int nb;
    rst_n = 1'b1;
    pc    = 64'h1000;
    repeat (2) @(negedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst", 64'(inst), 64'h1);
    check("rst_request", 64'(request), 64'd0);
    rst_n = 1'b0;

    // 1: cold miss at 0x1000
    @(negedge clk);
    #1;
    check("t1_request", 64'(request), 64'd1);
    check("t1_a_address", a_address, 64'h1000);
    check("t1_a_size", 64'(a_size), 64'd5);
    check("t1_a_opcode", 64'(a_opcode), 64'd4);
    check("t1_bubble", 64'(inst), 64'h1);
    wait_valid("t1_fill_timeout", 100);
    check("t1_inst", 64'(inst), 64'h1122_0197);

    // 2/3: same-cycle hits, compressed and uncompressed
    @(negedge clk);
    pc = 64'h1008;
    #1;
    check("t2_hit", 64'(inst_valid), 64'd1);
    check("t2_request", 64'(request), 64'd0);
    check("t3_word", 64'(inst), 64'h0000_0013);
    check("t3_word_comp", 64'(inst_compressed), 64'd0);
    @(negedge clk);
    pc = 64'h1004;
    #1;
    check("t3_half", 64'(inst), 64'h0000_4501);
    check("t3_half_comp", 64'(inst_compressed), 64'd1);

    // 4: 32-bit instruction straddling into an uncached line
    @(negedge clk);
    pc = 64'h101E;
    #1;
    check("t4_miss", 64'(inst_valid), 64'd0);
    wait_valid("t4_fill_timeout", 100);
    check("t4_inst", 64'(inst), 64'h1234_0513);

    // 5: conflicting tag on set 0
    @(negedge clk);
    pc = 64'h1800;
    #1;
    check("t5_miss", 64'(inst_valid), 64'd0);
    wait_valid("t5_fill_timeout", 100);
    check("t5_inst", 64'(inst), 64'hA9C2_A9C3);
    @(negedge clk);
    pc = 64'h1000;
    #1;
    check("t5_evicted", 64'(inst_valid), 64'd0);

    // 6: reset after two accepted beats of the 0x1000 refill
    nb = 0;
    for (int i = 0; i < 100 && nb < 2; i++) begin
      @(negedge clk);
      #1;
      if (d_valid && d_ready) nb++;
    end
    check("t6_two_beats", 64'(nb), 64'd2);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_no_valid", 64'(inst_valid), 64'd0);
    check("t6_request", 64'(request), 64'd0);
    wait_valid("t6_refill_timeout", 100);
    check("t6_inst", 64'(inst), 64'h1122_0197);

    // crossing with both lines absent: two back-to-back refills
    @(negedge clk);
    pc = 64'h103E;
    #1;
    check("t7_miss", 64'(inst_valid), 64'd0);
    wait_valid("t7_fill_timeout", 200);
    check("t7_inst", 64'(inst), 64'hADE3_0793);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
